// File: rtl/traffic_light.sv
// Single-approach traffic-light controller; every instance runs the same
// sequence so a PHASE=0 / PHASE=1 pair stays lock-step.
//
// state  | meaning
// A_GRN  | phase A (north-south) green
// A_YEL  | phase A yellow
// A_RED  | all-red clearance after phase A
// B_GRN  | phase B (east-west) green
// B_YEL  | phase B yellow
// B_RED  | all-red clearance after phase B
// EMERG  | emergency hold, all approaches red with flag
module traffic_light #(
  parameter int PHASE          = 0,
  parameter int GREEN_CYCLES   = 4,
  parameter int YELLOW_CYCLES  = 2,
  parameter int ALL_RED_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       emergency,
  output logic [3:0] out
);

  typedef enum logic [2:0] {
    A_GRN = 3'd0,
    A_YEL = 3'd1,
    A_RED = 3'd2,
    B_GRN = 3'd3,
    B_YEL = 3'd4,
    B_RED = 3'd5,
    EMERG = 3'd6
  } state_t;

  localparam logic [7:0] G_LD = 8'(GREEN_CYCLES - 1);
  localparam logic [7:0] Y_LD = 8'(YELLOW_CYCLES - 1);
  localparam logic [7:0] R_LD = 8'(ALL_RED_CYCLES - 1);

  localparam state_t GRN_S = (PHASE == 0) ? A_GRN : B_GRN;
  localparam state_t YEL_S = (PHASE == 0) ? A_YEL : B_YEL;

  state_t     state, state_nxt;
  logic [7:0] cnt, cnt_nxt;

  function automatic logic [7:0] load_of(input state_t s);
    case (s)
      A_GRN, B_GRN: load_of = G_LD;
      A_YEL, B_YEL: load_of = Y_LD;
      default:      load_of = R_LD;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= A_GRN;
      cnt   <= G_LD;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (emergency) begin
      state_nxt = EMERG;
    end else if (state == EMERG) begin
      // leave through clearance so phase A restarts with a full green
      state_nxt = B_RED;
      cnt_nxt   = R_LD;
    end else if (cnt != 8'd0) begin
      cnt_nxt = cnt - 8'd1;
    end else begin
      case (state)
        A_GRN:   state_nxt = A_YEL;
        A_YEL:   state_nxt = A_RED;
        A_RED:   state_nxt = B_GRN;
        B_GRN:   state_nxt = B_YEL;
        B_YEL:   state_nxt = B_RED;
        default: state_nxt = A_GRN;
      endcase
      cnt_nxt = load_of(state_nxt);
    end
  end

  always_comb begin
    out = 4'b0100;
    if (state == EMERG)      out = 4'b1100;
    else if (state == GRN_S) out = 4'b0001;
    else if (state == YEL_S) out = 4'b0010;
  end

endmodule

// File: tb/tb_traffic_light.sv
// Directed bench for traffic_light: default NS/EW pair plus a G=1,Y=1,R=2 pair,
// all sharing clk, rst and emergency.
module tb_traffic_light;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       emergency = 1'b0;
  logic [3:0] ns, ew, p0, p1;

  int checks = 0;
  int errors = 0;
  int k_def  = 0;
  int k_alt  = 0;

  always #5 clk = ~clk;

  traffic_light #(.PHASE(0)) u_ns (.clk(clk), .rst(rst), .emergency(emergency), .out(ns));
  traffic_light #(.PHASE(1)) u_ew (.clk(clk), .rst(rst), .emergency(emergency), .out(ew));
  traffic_light #(.PHASE(0), .GREEN_CYCLES(1), .YELLOW_CYCLES(1), .ALL_RED_CYCLES(2))
    u_p0 (.clk(clk), .rst(rst), .emergency(emergency), .out(p0));
  traffic_light #(.PHASE(1), .GREEN_CYCLES(1), .YELLOW_CYCLES(1), .ALL_RED_CYCLES(2))
    u_p1 (.clk(clk), .rst(rst), .emergency(emergency), .out(p1));

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Expected lamps k cycles after entering A_GRN with a fresh timer.
  function automatic logic [3:0] exp_out(input int phase, input int k,
                                         input int g, input int y, input int r);
    int p;
    p = k % (2 * (g + y + r));
    if (p < g)                    return (phase == 0) ? 4'b0001 : 4'b0100;
    if (p < g + y)                return (phase == 0) ? 4'b0010 : 4'b0100;
    if (p < g + y + r)            return 4'b0100;
    if (p < 2 * g + y + r)        return (phase == 1) ? 4'b0001 : 4'b0100;
    if (p < 2 * g + 2 * y + r)    return (phase == 1) ? 4'b0010 : 4'b0100;
    return 4'b0100;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_ns"}, ns, exp_out(0, k_def, 4, 2, 1));
    chk({tag, "_ew"}, ew, exp_out(1, k_def, 4, 2, 1));
    chk({tag, "_p0"}, p0, exp_out(0, k_alt, 1, 1, 2));
    chk({tag, "_p1"}, p1, exp_out(1, k_alt, 1, 1, 2));
  endtask

  task automatic run_check(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      step();
      k_def++;
      k_alt++;
      check_all(tag);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    k_def = 0;
    k_alt = 0;
    check_all("reset");
  endtask

  // Hold emergency for n edges, then release; exit lands in B_RED with a
  // fresh clearance timer, i.e. R cycles before the end of the period.
  task automatic emerg(input int n);
    emergency = 1'b1;
    for (int i = 0; i < n; i++) begin
      step();
      chk("emerg_ns", ns, 4'b1100);
      chk("emerg_ew", ew, 4'b1100);
      chk("emerg_p0", p0, 4'b1100);
      chk("emerg_p1", p1, 4'b1100);
    end
    emergency = 1'b0;
    step();
    k_def = 14 - 1;
    k_alt = 8 - 2;
    check_all("exit");
  endtask

  initial begin
    do_reset();
    run_check("free", 30);

    // emergency during NS green
    do_reset();
    run_check("pre", 1);
    emerg(3);
    run_check("recov", 6);

    // single-cycle pulse during EW yellow (k=11)
    do_reset();
    run_check("pre2", 11);
    chk("ew_yel", ew, 4'b0010);
    emerg(1);
    run_check("recov2", 5);

    // rst and emergency together mid-cycle
    run_check("mid", 3);
    emergency = 1'b1;
    rst = 1'b1;
    step();
    rst = 1'b0;
    emergency = 1'b0;
    k_def = 0;
    k_alt = 0;
    check_all("rst_emerg");
    chk("rst_flag", {7'd0, ns[3] | ew[3]}, 8'd0);
    run_check("post", 16);

    // randomized emergency/reset with safety invariants
    for (int i = 0; i < 1000; i++) begin
      if (i % 3 == 0) emergency = 1'($urandom_range(0, 1));
      rst = ($urandom_range(0, 49) == 0);
      step();
      chk("inv_grn",  {7'd0, ns[0] & ew[0]}, 8'd0);
      chk("inv_yel",  {7'd0, ns[1] & ew[1]}, 8'd0);
      chk("inv_pgrn", {7'd0, p0[0] & p1[0]}, 8'd0);
      chk("hot_ns",   8'($countones(ns[2:0])), 8'd1);
      chk("hot_ew",   8'($countones(ew[2:0])), 8'd1);
    end
    rst = 1'b0;
    emergency = 1'b0;

    do_reset();
    run_check("final", 16);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/traffic_light.md
Name: traffic_light

Overview:
- Moore-style single-direction traffic-light controller.
- Two instances, one per approach (PHASE=0 north-south, PHASE=1 east-west), share clk, rst and emergency.
- Every instance runs the same sequence FSM, so the instances stay lock-step and never show conflicting greens.
- An emergency input forces the approach to red with an emergency flag. The sequence resumes safely when emergency deasserts.

Parameters:
- PHASE, 0: 0 = approach is green in phase A (NS); 1 = approach is green in phase B (EW).
- GREEN_CYCLES, 4: clock cycles in each green state (1..255).
- YELLOW_CYCLES, 2: clock cycles in each yellow state (1..255).
- ALL_RED_CYCLES, 1: clock cycles in each all-red clearance state (1..255).

Ports:
- clk, input, 1: rising-edge clock.
- rst, input, 1: synchronous, active-high reset.
- emergency, input, 1: level-sensitive emergency request, sampled on rising clk.
- out, output, 4: lamp drive. [3] emergency flag, [2] red, [1] yellow, [0] green.

Behaviour:
- Single clock domain. All state changes occur on the rising edge of clk.
- out is decoded from registered state only; no combinational path from emergency to out.
- Exactly one of out[2:0] is high at all times after the first reset edge.
- out[3]=1 only in state EMERG.
- States: A_GRN, A_YEL, A_RED, B_GRN, B_YEL, B_RED, EMERG.
- Normal sequence: A_GRN -> A_YEL -> A_RED -> B_GRN -> B_YEL -> B_RED -> A_GRN, repeating.
- Dwell per state:
  - A_GRN and B_GRN hold GREEN_CYCLES.
  - A_YEL and B_YEL hold YELLOW_CYCLES.
  - A_RED and B_RED hold ALL_RED_CYCLES.
  - Full period = 2*(G+Y+R) cycles (14 at defaults).
- Dwell timer: 8-bit down-counter.
  - Loaded with (duration-1) on entry to a state.
  - State advances on the edge where the counter is 0 and no emergency is sampled.
- Output decode, PHASE=0:
  - A_GRN -> 4'b0001.
  - A_YEL -> 4'b0010.
  - All other non-emergency states -> 4'b0100.
- Output decode, PHASE=1:
  - B_GRN -> 4'b0001.
  - B_YEL -> 4'b0010.
  - All other non-emergency states -> 4'b0100.
- Emergency entry:
  - Any edge with emergency=1 and rst=0 moves the FSM to EMERG, from any state and at any counter value.
  - out becomes 4'b1100 after that edge (one-cycle latency).
  - The FSM remains in EMERG while emergency stays 1.
- Emergency exit:
  - The first edge with emergency=0 while in EMERG moves the FSM to B_RED, with the counter loaded with ALL_RED_CYCLES-1.
  - The FSM then enters A_GRN, so phase A always restarts with a fresh green after an emergency.
- Reset:
  - rst=1 on an edge moves the FSM to A_GRN with the counter loaded with GREEN_CYCLES-1.
  - rst has priority over emergency.
  - Reset mid-sequence or mid-emergency behaves identically.
- Reset output values:
  - PHASE=0: out=4'b0001.
  - PHASE=1: out=4'b0100.
- Before the first reset, out is undefined. Benches apply rst for at least one edge.
- Safety invariant: across a PHASE=0 and a PHASE=1 instance, out[0] or out[1] is never high in both simultaneously.
- Single-cycle emergency pulse: exactly one cycle of 4'b1100, then ALL_RED_CYCLES of red, then normal A_GRN.

Test Plan:
- Reset then free-run with defaults and emergency=0 -> NS out: 0001 for 4 cycles, 0010 for 2, 0100 for 8, then repeats. EW out: 0100 for 7, 0001 for 4, 0010 for 2, 0100 for 1, period 14.
- Assert emergency for 3 cycles during NS green -> both out=1100 starting the edge after assertion for 3 cycles. Then both 0100 for 1 cycle, then NS 0001 / EW 0100.
- Emergency pulse of 1 cycle during EW yellow -> one cycle 1100 on both, then recovery as above. No remaining EW yellow is shown.
- Assert rst and emergency together mid-cycle -> after the edge NS=0001, EW=0100, and out[3]=0.
- Run 1000 cycles with emergency toggling every few cycles and random rst -> the no-simultaneous-green/yellow invariant is checked every cycle. out[2:0] is always one-hot.
- Non-default parameters G=1, Y=1, R=2 -> every dwell equals its parameter, period 8. G=1 gives a single-cycle green.
